// File: rtl/sn76489_pkg.sv
// Shared register codes, noise-rate encodings and reset values for the SN76489 front end.
package sn76489_pkg;

    typedef enum logic [2:0] {
        REG_TONE0_FREQ = 3'b000,
        REG_TONE0_VOL  = 3'b001,
        REG_TONE1_FREQ = 3'b010,
        REG_TONE1_VOL  = 3'b011,
        REG_TONE2_FREQ = 3'b100,
        REG_TONE2_VOL  = 3'b101,
        REG_NOISE_CTRL = 3'b110,
        REG_NOISE_VOL  = 3'b111
    } sn_reg_e;

    typedef enum logic [1:0] {
        NOISE_RATE_16    = 2'b00,
        NOISE_RATE_32    = 2'b01,
        NOISE_RATE_64    = 2'b10,
        NOISE_RATE_TONE2 = 2'b11
    } noise_rate_e;

    localparam logic [9:0] NOISE_PERIOD_16 = 10'h010;
    localparam logic [9:0] NOISE_PERIOD_32 = 10'h020;
    localparam logic [9:0] NOISE_PERIOD_64 = 10'h040;

    localparam logic [3:0] ATT_SILENT = 4'hF;

    // Latch bytes carry the low nibble of a period, data bytes the upper six bits.
    function automatic logic [9:0] tone_freq_update(input logic [9:0] old_n,
                                                    input logic [7:0] wbyte);
        logic [9:0] n;
        n = old_n;
        if (wbyte[7]) n[3:0] = wbyte[3:0];
        else          n[9:4] = wbyte[5:0];
        return n;
    endfunction

endpackage

// File: rtl/sn76489_register_controller_if.sv
// CPU write bus of the SN76489: byte strobe plus chip-style ready handshake.
interface sn76489_register_controller_if;
    logic       wr;
    logic [7:0] data;
    logic       ready;

    modport master (output wr, output data, input ready);
    modport slave  (input wr, input data, output ready);
endinterface

// File: rtl/sn76489_prescaler.sv
// Free-running divide-by-CLK_DIV tick shared by the tone and noise generators.
module sn76489_prescaler #(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic clk,
    input  logic reset_n,
    output logic enable
);
    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    always_comb begin
        cnt_next = (cnt == LAST) ? '0 : cnt + 1'b1;
    end

    // enable is registered but aligned with the cycle in which cnt sits at LAST
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            enable <= 1'b0;
        end else begin
            cnt    <= cnt_next;
            enable <= (cnt_next == LAST);
        end
    end
endmodule

// File: rtl/sn76489_register_controller.sv
// SN76489 register front end: latch/data byte decode, register file, busy handshake.
module sn76489_register_controller
    import sn76489_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 16,
    parameter int unsigned BUSY_CYCLES = 32
) (
    input  logic                          clk,
    input  logic                          reset_n,
    sn76489_register_controller_if.slave  bus,
    output logic                          enable,
    output logic [9:0]                    tone0N,
    output logic [9:0]                    tone1N,
    output logic [9:0]                    tone2N,
    output logic [3:0]                    tone0Att,
    output logic [3:0]                    tone1Att,
    output logic [3:0]                    tone2Att,
    output logic [9:0]                    noiseN,
    output logic                          noiseFeedbackType,
    output logic [3:0]                    noiseAtt,
    output logic                          noiseReset
);
    localparam int unsigned BW = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
    localparam logic [BW-1:0] BUSY_LOAD = BW'(BUSY_CYCLES - 1);

    sn76489_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable)
    );

    sn_reg_e     latched;
    sn_reg_e     target;
    noise_rate_e rate;
    logic        accept;
    logic [BW-1:0] busy_cnt;
    logic [9:0]  tone_n0, tone_n1, tone_n2;
    logic [3:0]  att [4];
    logic        fb;
    logic        nreset_q;
    logic        ready_q;

    always_comb begin
        accept = bus.wr && ready_q;
        target = bus.data[7] ? sn_reg_e'(bus.data[6:4]) : latched;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_q  <= 1'b1;
            busy_cnt <= '0;
        end else if (accept) begin
            ready_q  <= 1'b0;
            busy_cnt <= BUSY_LOAD;
        end else if (!ready_q) begin
            if (busy_cnt == '0) ready_q  <= 1'b1;
            else                busy_cnt <= busy_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            latched  <= REG_TONE0_FREQ;
            tone_n0  <= '0;
            tone_n1  <= '0;
            tone_n2  <= '0;
            for (int unsigned i = 0; i < 4; i++) att[i] <= ATT_SILENT;
            fb       <= 1'b0;
            rate     <= NOISE_RATE_16;
            nreset_q <= 1'b0;
        end else begin
            nreset_q <= 1'b0;
            if (accept) begin
                if (bus.data[7]) latched <= target;
                case (target)
                    REG_TONE0_FREQ: tone_n0 <= tone_freq_update(tone_n0, bus.data);
                    REG_TONE1_FREQ: tone_n1 <= tone_freq_update(tone_n1, bus.data);
                    REG_TONE2_FREQ: tone_n2 <= tone_freq_update(tone_n2, bus.data);
                    REG_NOISE_CTRL: begin
                        fb       <= bus.data[2];
                        rate     <= noise_rate_e'(bus.data[1:0]);
                        nreset_q <= 1'b1;
                    end
                    // remaining codes are the four volume registers, indexed by channel
                    default: att[target[2:1]] <= bus.data[3:0];
                endcase
            end
        end
    end

    always_comb begin
        case (rate)
            NOISE_RATE_16: noiseN = NOISE_PERIOD_16;
            NOISE_RATE_32: noiseN = NOISE_PERIOD_32;
            NOISE_RATE_64: noiseN = NOISE_PERIOD_64;
            default:       noiseN = tone_n2;
        endcase
    end

    assign bus.ready         = ready_q;
    assign tone0N            = tone_n0;
    assign tone1N            = tone_n1;
    assign tone2N            = tone_n2;
    assign tone0Att          = att[0];
    assign tone1Att          = att[1];
    assign tone2Att          = att[2];
    assign noiseAtt          = att[3];
    assign noiseFeedbackType = fb;
    assign noiseReset        = nreset_q;
endmodule

// File: tb/tb_sn76489_register_controller.sv
// Directed bench for the SN76489 register front end: write table plus handshake/reset sequences.
module tb_sn76489_register_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [9:0] tone0N, tone1N, tone2N, noiseN;
    logic [3:0] tone0Att, tone1Att, tone2Att, noiseAtt;
    logic       noiseFeedbackType, noiseReset;

    int errors = 0;
    int checks = 0;
    int nr_count = 0;

    sn76489_register_controller_if bus ();

    sn76489_register_controller #(.CLK_DIV(16), .BUSY_CYCLES(32)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .bus               (bus),
        .enable            (enable),
        .tone0N            (tone0N),
        .tone1N            (tone1N),
        .tone2N            (tone2N),
        .tone0Att          (tone0Att),
        .tone1Att          (tone1Att),
        .tone2Att          (tone2Att),
        .noiseN            (noiseN),
        .noiseFeedbackType (noiseFeedbackType),
        .noiseAtt          (noiseAtt),
        .noiseReset        (noiseReset)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (noiseReset) nr_count++;

    typedef struct {
        logic [7:0] din;
        logic [9:0] t0, t1, t2, nn;
        logic [3:0] a0, a1, a2, an;
        logic       fb;
        int         nr;
    } vec_t;

    vec_t vec [13];

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int unsigned guard = 0;
        while (bus.ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (bus.ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got %b expected 1", bus.ready);
        end
    endtask

    // Entered and left on a falling edge; the byte is sampled at the rising edge in between.
    task automatic do_write(input logic [7:0] b);
        wait_ready();
        bus.wr   = 1'b1;
        bus.data = b;
        @(negedge clk);
        bus.wr   = 1'b0;
    endtask

    initial begin
        int nr_before;

        reset_n  = 1'b0;
        bus.wr   = 1'b0;
        bus.data = '0;

        vec[0]  = '{8'h8E, 10'h00E, 10'h000, 10'h000, 10'h010, 4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 0};
        vec[1]  = '{8'h0F, 10'h0FE, 10'h000, 10'h000, 10'h010, 4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 0};
        vec[2]  = '{8'hBA, 10'h0FE, 10'h000, 10'h000, 10'h010, 4'hF, 4'hA, 4'hF, 4'hF, 1'b0, 0};
        vec[3]  = '{8'h03, 10'h0FE, 10'h000, 10'h000, 10'h010, 4'hF, 4'h3, 4'hF, 4'hF, 1'b0, 0};
        vec[4]  = '{8'hE5, 10'h0FE, 10'h000, 10'h000, 10'h020, 4'hF, 4'h3, 4'hF, 4'hF, 1'b1, 1};
        vec[5]  = '{8'hC3, 10'h0FE, 10'h000, 10'h003, 10'h020, 4'hF, 4'h3, 4'hF, 4'hF, 1'b1, 0};
        vec[6]  = '{8'h3F, 10'h0FE, 10'h000, 10'h3F3, 10'h020, 4'hF, 4'h3, 4'hF, 4'hF, 1'b1, 0};
        vec[7]  = '{8'hE7, 10'h0FE, 10'h000, 10'h3F3, 10'h3F3, 4'hF, 4'h3, 4'hF, 4'hF, 1'b1, 1};
        vec[8]  = '{8'hC0, 10'h0FE, 10'h000, 10'h3F0, 10'h3F0, 4'hF, 4'h3, 4'hF, 4'hF, 1'b1, 0};
        vec[9]  = '{8'hE4, 10'h0FE, 10'h000, 10'h3F0, 10'h010, 4'hF, 4'h3, 4'hF, 4'hF, 1'b1, 1};
        vec[10] = '{8'h02, 10'h0FE, 10'h000, 10'h3F0, 10'h040, 4'hF, 4'h3, 4'hF, 4'hF, 1'b0, 1};
        vec[11] = '{8'hF7, 10'h0FE, 10'h000, 10'h3F0, 10'h040, 4'hF, 4'h3, 4'hF, 4'h7, 1'b0, 0};
        vec[12] = '{8'h59, 10'h0FE, 10'h000, 10'h3F0, 10'h040, 4'hF, 4'h3, 4'hF, 4'h9, 1'b0, 0};

        repeat (3) @(negedge clk);
        chk("rst_ready", 10'(bus.ready), 10'd1);
        chk("rst_enable", 10'(enable), 10'd0);
        chk("rst_noiseReset", 10'(noiseReset), 10'd0);
        chk("rst_tone0N", tone0N, 10'h000);
        chk("rst_tone1N", tone1N, 10'h000);
        chk("rst_tone2N", tone2N, 10'h000);
        chk("rst_tone0Att", 10'(tone0Att), 10'hF);
        chk("rst_tone1Att", 10'(tone1Att), 10'hF);
        chk("rst_tone2Att", 10'(tone2Att), 10'hF);
        chk("rst_noiseAtt", 10'(noiseAtt), 10'hF);
        chk("rst_noiseN", noiseN, 10'h010);
        chk("rst_fb", 10'(noiseFeedbackType), 10'd0);

        // Prescaler: after edge k following release, enable is high only when k mod 16 == 15.
        reset_n = 1'b1;
        for (int k = 1; k <= 48; k++) begin
            @(negedge clk);
            chk($sformatf("enable_k%0d", k), 10'(enable), 10'((k % 16) == 15));
        end

        for (int i = 0; i < 13; i++) begin
            nr_before = nr_count;
            do_write(vec[i].din);
            wait_ready();
            chk($sformatf("v%0d_tone0N", i), tone0N, vec[i].t0);
            chk($sformatf("v%0d_tone1N", i), tone1N, vec[i].t1);
            chk($sformatf("v%0d_tone2N", i), tone2N, vec[i].t2);
            chk($sformatf("v%0d_noiseN", i), noiseN, vec[i].nn);
            chk($sformatf("v%0d_tone0Att", i), 10'(tone0Att), 10'(vec[i].a0));
            chk($sformatf("v%0d_tone1Att", i), 10'(tone1Att), 10'(vec[i].a1));
            chk($sformatf("v%0d_tone2Att", i), 10'(tone2Att), 10'(vec[i].a2));
            chk($sformatf("v%0d_noiseAtt", i), 10'(noiseAtt), 10'(vec[i].an));
            chk($sformatf("v%0d_fb", i), 10'(noiseFeedbackType), 10'(vec[i].fb));
            chk($sformatf("v%0d_noiseResetPulses", i), 10'(nr_count - nr_before), 10'(vec[i].nr));
        end

        // noiseReset coincides with the first cycle showing the new noise-control value.
        wait_ready();
        nr_before = nr_count;
        do_write(8'hE6);
        chk("nr_same_cycle", 10'(noiseReset), 10'd1);
        chk("nr_same_cycle_noiseN", noiseN, 10'h040);
        @(negedge clk);
        chk("nr_one_cycle", 10'(noiseReset), 10'd0);
        chk("nr_pulses", 10'(nr_count - nr_before), 10'd1);

        // Busy handshake: accept at cycle t, ignored write at t+5, re-accept at t+33.
        wait_ready();
        bus.wr   = 1'b1;
        bus.data = 8'h9F;
        @(negedge clk);
        bus.wr = 1'b0;
        chk("busy_latency_att", 10'(tone0Att), 10'hF);
        for (int k = 1; k <= 33; k++) begin
            chk($sformatf("busy_ready_t%0d", k), 10'(bus.ready), 10'(k == 33));
            if (k == 5) begin
                bus.wr   = 1'b1;
                bus.data = 8'h90;
            end
            if (k == 6) bus.wr = 1'b0;
            if (k == 10) chk("ignored_write_att", 10'(tone0Att), 10'hF);
            if (k == 33) begin
                bus.wr   = 1'b1;
                bus.data = 8'h90;
            end
            @(negedge clk);
        end
        bus.wr = 1'b0;
        chk("reaccept_att", 10'(tone0Att), 10'h0);
        chk("reaccept_ready", 10'(bus.ready), 10'd0);

        // Asynchronous reset in the middle of a busy window.
        wait_ready();
        do_write(8'hD4);
        chk("pre_reset_tone2Att", 10'(tone2Att), 10'h4);
        chk("pre_reset_ready", 10'(bus.ready), 10'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("async_ready", 10'(bus.ready), 10'd1);
        chk("async_tone2Att", 10'(tone2Att), 10'hF);
        chk("async_tone0N", tone0N, 10'h000);
        chk("async_noiseN", noiseN, 10'h010);
        chk("async_enable", 10'(enable), 10'd0);
        @(negedge clk);
        reset_n = 1'b1;
        do_write(8'h01);
        wait_ready();
        chk("post_reset_tone0N", tone0N, 10'h010);
        chk("post_reset_tone2N", tone2N, 10'h000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
